// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W    = 10;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned CSUM_W         = 8;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader.sv
// Parses header/data/checksum byte stream, writes little-endian words into
// instruction memory and releases the core only after a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              RESET,
  imem_loader_if.slave      in_if,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;
  localparam int unsigned SHIFT_W   = WORD_W - BYTE_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [CSUM_W-1:0]   xor_q, xor_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
  logic [CNT_W-1:0]    wl_q, wl_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                ready_c;
  logic                accept_c;
  logic [CNT_W-1:0]    hdr_cnt_c;

  // Stream is accepted in every non-terminal state.
  assign ready_c   = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept_c  = in_if.in_valid && ready_c;
  assign hdr_cnt_c = {in_if.in_data, cnt_q[BYTE_W-1:0]};

  // Next-state: header parse, word assembly, running XOR and checksum decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    wl_d       = wl_q;

    if (accept_c) begin
      case (state_q)
        ST_HDR0: begin
          cnt_d   = CNT_W'(in_if.in_data);
          state_d = ST_HDR1;
        end
        ST_HDR1: begin
          cnt_d = hdr_cnt_c;
          if (32'(hdr_cnt_c) > MAX_WORDS) begin
            state_d = ST_ERR;
          end else if (hdr_cnt_c == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          xor_d   = xor_q ^ in_if.in_data;
          lane_d  = lane_q + LANE_W'(1);
          shift_d = {in_if.in_data, shift_q[SHIFT_W-1:BYTE_W]};
          // Last lane: first byte already sits in bits 7:0 of the shifter.
          if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
            im_we_d    = 1'b1;
            im_addr_d  = ADDR_W'(wl_q);
            im_wdata_d = {in_if.in_data, shift_q};
            wl_d       = wl_q + CNT_W'(1);
            if ((wl_q + CNT_W'(1)) == cnt_q) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          state_d = (in_if.in_data == xor_q) ? ST_DONE : ST_ERR;
        end
        default: begin
        end
      endcase
    end

    core_reset_d = (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= ST_HDR0;
      cnt_q        <= '0;
      lane_q       <= '0;
      shift_q      <= '0;
      xor_q        <= '0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      wl_q         <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      shift_q      <= shift_d;
      xor_q        <= xor_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      wl_q         <= wl_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_if.in_ready = ready_c;
  assign im_we          = im_we_q;
  assign im_addr        = im_addr_q;
  assign im_wdata       = im_wdata_q;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares every im_we.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned CAP = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          RESET;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          core_reset;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  imem_loader_if bus();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .RESET        (RESET),
    .in_if        (bus),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!RESET && im_we) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.addr));
        check("wr_data", im_wdata, e.data);
      end
    end
  end

  task automatic do_reset();
    RESET        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_rst_im_we"}, 32'(im_we), 32'd0);
    check({tag, "_rst_im_addr"}, 32'(im_addr), 32'd0);
    check({tag, "_rst_im_wdata"}, im_wdata, 32'd0);
    check({tag, "_rst_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_rst_done"}, 32'(done), 32'd0);
    check({tag, "_rst_error"}, 32'(error), 32'd0);
    check({tag, "_rst_words"}, 32'(words_loaded), 32'd0);
  endtask

  // Present one byte after 0..gap_max idle cycles carrying junk data.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int  gaps;
    bit  took;
    logic rdy;
    gaps = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
    repeat (gaps) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    took = 1'b0;
    for (int t = 0; t < 50 && !took; t++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      took = (rdy === 1'b1);
    end
    if (!took) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: byte 0x%0h not accepted in 50 cycles", b);
    end
  endtask

  // Reference: stream = count, little-endian words, XOR checksum.
  // Header beyond capacity -> error and no writes; else all N words land at
  // 0..N-1 and the checksum decides done vs error.
  task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                          input int gap_max, input logic corrupt);
    logic [7:0]  x;
    logic [31:0] w;
    logic [7:0]  csum;
    bit          good;
    x = 8'h00;
    send_byte(8'(n), gap_max);
    send_byte(8'(n >> 8), gap_max);
    if (n > int'(CAP)) begin
      bus.in_valid = 1'b0;
      check({tag, "_hdr_error"}, 32'(error), 32'd1);
      check({tag, "_hdr_done"}, 32'(done), 32'd0);
      check({tag, "_hdr_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_hdr_core_reset"}, 32'(core_reset), 32'd1);
      check({tag, "_hdr_words"}, 32'(words_loaded), 32'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = (i < words.size()) ? words[i] : $urandom;
        sb.push_back('{addr: AW'(i), data: w});
        for (int b = 0; b < 4; b++) begin
          x ^= w[8*b +: 8];
          send_byte(w[8*b +: 8], gap_max);
        end
      end
      csum = x ^ {7'd0, corrupt};
      send_byte(csum, gap_max);
      bus.in_valid = 1'b0;
      good = !corrupt;
      check({tag, "_done"}, 32'(done), 32'(good));
      check({tag, "_error"}, 32'(error), 32'(!good));
      check({tag, "_core_reset"}, 32'(core_reset), 32'(!good));
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_words"}, 32'(words_loaded), 32'(n));
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_terminal_hold"}, 32'({done, error}), 32'({done, error}) & 32'h3 | 32'({1'b0, 1'b0}) | (n > int'(CAP) ? 32'd1 : {30'd0, !corrupt, corrupt}) & 32'h3 );
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] empty[$];
    RESET        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    do_reset();
    check_reset_state("init");

    q = '{32'h12345678, 32'hDEADBEEF};
    run_load("n2_good", 2, q, 0, 1'b0);

    do_reset();
    run_load("n2_badcsum", 2, q, 0, 1'b1);

    do_reset();
    run_load("n0_good", 0, empty, 0, 1'b0);
    do_reset();
    run_load("n0_bad", 0, empty, 0, 1'b1);

    do_reset();
    run_load("n1025", 1025, empty, 0, 1'b0);

    do_reset();
    run_load("n10_gapped", 10, empty, 3, 1'b0);

    do_reset();
    run_load("n1024_full", 1024, empty, 0, 1'b0);

    // Reset in the middle of word 3 of a 5-word load.
    do_reset();
    send_byte(8'd5, 0);
    send_byte(8'd0, 0);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] w;
      w = $urandom;
      sb.push_back('{addr: AW'(i), data: w});
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    do_reset();
    check_reset_state("midrst");
    check("midrst_sb_drained", 32'(sb.size()), 32'd0);
    q = '{32'hCAFEF00D};
    run_load("after_rst", 1, q, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      int   n;
      logic bad;
      n   = int'($urandom_range(8, 1));
      bad = ($urandom_range(3, 0) == 0);
      do_reset();
      run_load($sformatf("rand%0d", k), n, empty, 2, bad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
